// File: rtl/menu_input_ctrl_pkg.sv
// Shared encodings for the Pong joystick menu front end:
// debouncer state codes and pause-menu selection values.
package pong_pkg;

    typedef enum logic [1:0] {
        RELEASED        = 2'b00,
        PRESS_PENDING   = 2'b01,
        PRESSED         = 2'b10,
        RELEASE_PENDING = 2'b11
    } deb_state_t;

    localparam logic VAL_CONTINUE = 1'b0;
    localparam logic VAL_RESTART  = 1'b1;

endpackage

// File: rtl/menu_input_ctrl_if.sv
// Board-side joystick pins, main-FSM mode inputs and the
// enter/value pair returned to the main FSM.
interface menu_input_ctrl_if;

    logic btn_raw;
    logic up_raw;
    logic down_raw;
    logic enable_start;
    logic enable_pause;
    logic enter;
    logic value;

    modport master (
        output btn_raw, up_raw, down_raw,
        output enable_start, enable_pause,
        input  enter, value
    );

    modport slave (
        input  btn_raw, up_raw, down_raw,
        input  enable_start, enable_pause,
        output enter, value
    );

endinterface

// File: rtl/menu_input_ctrl_debouncer.sv
// Two-flop synchroniser plus counter FSM for one contact;
// emits the debounced level and a one-cycle registered rise pulse.
module button_debouncer
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             s1;
    logic             s2;
    deb_state_t       state;
    deb_state_t       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             rise_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= RELEASED;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_n;
            cnt   <= cnt_n;
            rise  <= rise_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            RELEASED: begin
                if (s2) begin
                    state_n = PRESS_PENDING;
                    cnt_n   = CNT_W'(1);
                end
            end
            PRESS_PENDING: begin
                if (!s2) begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                end else if (cnt == LIMIT) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_n = RELEASE_PENDING;
                    cnt_n   = CNT_W'(1);
                end
            end
            RELEASE_PENDING: begin
                if (s2) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == LIMIT) begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

    // Rise fires only on the accepting transition, never on release.
    always_comb begin
        rise_n = (state == PRESS_PENDING) && s2 && (cnt == LIMIT);
    end

    assign level = (state == PRESSED) || (state == RELEASE_PENDING);

endmodule

// File: rtl/menu_input_ctrl.sv
// Joystick front end: debounced enter pulse for the main FSM and
// the Continue/Restart selection held while the pause menu is shown.
module menu_input_ctrl
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input logic         clock,
    input logic         reset,
    menu_input_ctrl_if.slave bus
);

    logic       btn_rise;
    logic       up_rise;
    logic       down_rise;
    logic [2:0] level_unused;
    logic       pause_q;
    logic       value_q;
    logic       value_n;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_btn (
        .clock(clock),
        .reset(reset),
        .raw  (bus.btn_raw),
        .level(level_unused[0]),
        .rise (btn_rise)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_up (
        .clock(clock),
        .reset(reset),
        .raw  (bus.up_raw),
        .level(level_unused[1]),
        .rise (up_rise)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_down (
        .clock(clock),
        .reset(reset),
        .raw  (bus.down_raw),
        .level(level_unused[2]),
        .rise (down_rise)
    );

    // An enter pulse freezes the selection so the FSM sees the old value.
    always_comb begin
        value_n = value_q;
        if (bus.enable_start || !bus.enable_pause) begin
            value_n = VAL_CONTINUE;
        end else if (!pause_q) begin
            value_n = VAL_CONTINUE;
        end else if (btn_rise) begin
            value_n = value_q;
        end else if (up_rise && !down_rise) begin
            value_n = VAL_CONTINUE;
        end else if (down_rise && !up_rise) begin
            value_n = VAL_RESTART;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pause_q <= 1'b0;
            value_q <= VAL_CONTINUE;
        end else begin
            pause_q <= bus.enable_pause;
            value_q <= value_n;
        end
    end

    assign bus.enter = btn_rise;
    assign bus.value = value_q;

endmodule
